fpu_pipe_ctl: RTL

Floating-point pipeline controller and FP register file: the FPU-side end of the integer-unit/FPU interface. It receives decoded FP fields, the lwc1 writeback and forwarding selects from the integer pipeline. It returns per-stage destination tags, write flags, E3 result data, the swc1 store operand and the div/sqrt stall. Arithmetic datapaths (add/sub/mul/div/sqrt) are separate blocks: they take operands from E1 and return the E3 result on `ar`.

---
 rtl/fpu_pipe_ctl.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/fpu_pipe_ctl.sv
// FPU pipeline controller: ID operand select, E1/E2/E3 stage tracking, div/sqrt stall and a 32x32 FP register file.
// Optional feature macro: FPU_WRITE_BYPASS_EN (register-file reads return same-cycle write data).
module fpu_pipe_ctl #(
    parameter int DIV_CYCLES = 12
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [4:0]  fs,
    input  logic [4:0]  ft,
    input  logic [4:0]  fd,
    input  logic [2:0]  fc,
    input  logic        fasmds,
    input  logic        wf,
    input  logic        fwdla,
    input  logic        fwdlb,
    input  logic        fwdfa,
    input  logic        fwdfb,
    input  logic [31:0] mmo,
    input  logic        wwfpr,
    input  logic [4:0]  wrn,
    input  logic [31:0] wmo,
    input  logic [31:0] ar,
    output logic [4:0]  e1n,
    output logic [4:0]  e2n,
    output logic [4:0]  e3n,
    output logic        e1w,
    output logic        e2w,
    output logic        e3w,
    output logic [31:0] e3d,
    output logic [31:0] dfb,
    output logic [31:0] opa,
    output logic [31:0] opb,
    output logic [2:0]  efc,
    output logic        ev1,
    output logic        stall,
    output logic        st
);

    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD  = CW'(DIV_CYCLES - 1);
    localparam logic          DIV_MULTI = (DIV_CYCLES > 1) ? 1'b1 : 1'b0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } div_state_t;

    div_state_t     state_r;
    div_state_t     state_s;
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  cnt_s;

    logic [31:0]    rf_r [32];
    logic [31:0]    rd_fs_s;
    logic [31:0]    rd_ft_s;
    logic [31:0]    opa_s;
    logic [31:0]    opb_s;
    logic [2:0]     fc_norm_s;
    logic           is_div_s;
    logic           stall_s;

    logic           e1_v_r;
    logic           e1_w_r;
    logic [4:0]     e1_n_r;
    logic [2:0]     e1_fc_r;
    logic [31:0]    e1_a_r;
    logic [31:0]    e1_b_r;
    logic           st_r;
    logic           e2_w_r;
    logic [4:0]     e2_n_r;
    logic           e3_w_r;
    logic [4:0]     e3_n_r;

`ifdef FPU_WRITE_BYPASS_EN
    // Same-cycle write data overrides the stored word; the E3 port outranks the load port.
    function automatic logic [31:0] bypass_sel(
        input logic [4:0]  addr,
        input logic [31:0] stored,
        input logic        p_we,
        input logic [4:0]  p_n,
        input logic [31:0] p_d,
        input logic        l_we,
        input logic [4:0]  l_n,
        input logic [31:0] l_d
    );
        logic [31:0] val;
        if (p_we && (p_n == addr)) begin
            val = p_d;
        end else if (l_we && (l_n == addr)) begin
            val = l_d;
        end else begin
            val = stored;
        end
        return val;
    endfunction
`endif

    // Register-file read ports for fs and ft.
    always_comb begin
        rd_fs_s = rf_r[fs];
        rd_ft_s = rf_r[ft];
`ifdef FPU_WRITE_BYPASS_EN
        rd_fs_s = bypass_sel(fs, rf_r[fs], e3_w_r, e3_n_r, ar, wwfpr, wrn, wmo);
        rd_ft_s = bypass_sel(ft, rf_r[ft], e3_w_r, e3_n_r, ar, wwfpr, wrn, wmo);
`endif
    end

    // ID operand select: load-data forwarding outranks E3 forwarding.
    always_comb begin
        opa_s = rd_fs_s;
        opb_s = rd_ft_s;
        if (fwdla) begin
            opa_s = mmo;
        end else if (fwdfa) begin
            opa_s = ar;
        end else begin
            opa_s = rd_fs_s;
        end
        if (fwdlb) begin
            opb_s = mmo;
        end else if (fwdfb) begin
            opb_s = ar;
        end else begin
            opb_s = rd_ft_s;
        end
    end

    // Op decode: unused encodings are presented downstream as add.
    always_comb begin
        fc_norm_s = 3'b000;
        case (fc)
            3'b000:  fc_norm_s = 3'b000;
            3'b001:  fc_norm_s = 3'b001;
            3'b010:  fc_norm_s = 3'b010;
            3'b011:  fc_norm_s = 3'b011;
            3'b100:  fc_norm_s = 3'b100;
            default: fc_norm_s = 3'b000;
        endcase
        is_div_s = fasmds && ((fc == 3'b011) || (fc == 3'b100));
    end

    assign stall_s = (state_r == ST_BUSY) && (cnt_r != {CW{1'b0}});

    // Div/sqrt occupancy FSM next-state logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (is_div_s && DIV_MULTI) begin
                    state_s = ST_BUSY;
                    cnt_s   = CNT_LOAD;
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = {CW{1'b0}};
                end
            end
            ST_BUSY: begin
                if (cnt_r <= CW'(1)) begin
                    state_s = ST_IDLE;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = ST_BUSY;
                    cnt_s   = cnt_r - CW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Div/sqrt FSM state and countdown registers.
    always_ff @(posedge clk) begin
        if (clrn) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Stage registers: during a stall E1 holds, E2 takes a bubble and E3 drains.
    always_ff @(posedge clk) begin
        if (clrn) begin
            e1_v_r  <= 1'b0;
            e1_w_r  <= 1'b0;
            e1_n_r  <= 5'd0;
            e1_fc_r <= 3'b000;
            e1_a_r  <= 32'h0000_0000;
            e1_b_r  <= 32'h0000_0000;
            st_r    <= 1'b0;
            e2_w_r  <= 1'b0;
            e2_n_r  <= 5'd0;
            e3_w_r  <= 1'b0;
            e3_n_r  <= 5'd0;
        end else if (!stall_s) begin
            e1_v_r  <= fasmds;
            e1_w_r  <= fasmds && wf;
            e1_n_r  <= fd;
            e1_fc_r <= fc_norm_s;
            e1_a_r  <= opa_s;
            e1_b_r  <= opb_s;
            st_r    <= is_div_s;
            e2_w_r  <= e1_w_r;
            e2_n_r  <= e1_n_r;
            e3_w_r  <= e2_w_r;
            e3_n_r  <= e2_n_r;
        end else begin
            st_r    <= 1'b0;
            e2_w_r  <= 1'b0;
            e2_n_r  <= 5'd0;
            e3_w_r  <= e2_w_r;
            e3_n_r  <= e2_n_r;
        end
    end

    // Register file: E3 result port has priority over the lwc1 port on the same address.
    always_ff @(posedge clk) begin
        if (clrn) begin
            for (int i = 0; i < 32; i++) begin
                rf_r[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (e3_w_r && (e3_n_r == 5'(i))) begin
                    rf_r[i] <= ar;
                end else if (wwfpr && (wrn == 5'(i))) begin
                    rf_r[i] <= wmo;
                end else begin
                    rf_r[i] <= rf_r[i];
                end
            end
        end
    end

    assign e1n   = e1_n_r;
    assign e2n   = e2_n_r;
    assign e3n   = e3_n_r;
    assign e1w   = e1_w_r;
    assign e2w   = e2_w_r;
    assign e3w   = e3_w_r;
    assign e3d   = ar;
    assign dfb   = rd_ft_s;
    assign opa   = e1_a_r;
    assign opb   = e1_b_r;
    assign efc   = e1_fc_r;
    assign ev1   = e1_v_r;
    assign stall = stall_s;
    assign st    = st_r;

endmodule
